// File: rtl/full_adder_bist.sv
// Built-in self-test sequencer for a single full-adder tile.
// It applies all eight {a,b,cin} vectors, ROUNDS times over, to the adder
// under test. Each vector is held for LAT+1 cycles. In the last cycle of
// each vector, the adder response is compared against a golden model.
// When the run ends, the sequencer reports pass/fail, a saturating error
// count and the first failing vector.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; results of the last run are held
// S_RUN    | sweeping vectors; one sample per vector at stage == LAT
// S_FINISH | one-cycle end of run; done pulses, pass is valid from here on
module full_adder_bist #(
    parameter int LAT    = 0,
    parameter int ROUNDS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_cin,
    input  logic       dut_sum,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [2:0] LAT_L      = 3'(LAT);
    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    logic [1:0] r_state;
    logic [2:0] r_vec;
    logic [2:0] r_stage;
    logic [7:0] r_round;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_err;
    logic [2:0] r_ffv;
    logic       r_ffvalid;

    logic       w_gold_sum;
    logic       w_gold_cout;
    logic       w_mis;
    logic       w_sample;
    logic       w_last;
    logic [7:0] w_err_next;

    // Golden full-adder response for the vector currently on the bus
    assign w_gold_sum  = r_vec[2] ^ r_vec[1] ^ r_vec[0];
    assign w_gold_cout = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);

    // A wrong sum and a wrong cout on the same vector count as one error
    assign w_mis      = (dut_sum != w_gold_sum) || (dut_cout != w_gold_cout);
    assign w_sample   = (r_state == S_RUN) && (r_stage == LAT_L);
    assign w_last     = w_sample && (r_vec == 3'd7) && (r_round == LAST_ROUND);
    assign w_err_next = (w_sample && w_mis && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;

    // r_vec drives the adder directly. It is 0 outside RUN because every
    // sweep wraps 7 -> 0 and each start reloads it to 0.
    assign dut_a            = r_vec[2];
    assign dut_b            = r_vec[1];
    assign dut_cin          = r_vec[0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_vec   = r_ffv;
    assign first_fail_valid = r_ffvalid;

    // Sequencer: state, vector/stage/round counters, busy and done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vec   <= 3'd0;
            r_stage <= 3'd0;
            r_round <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_vec   <= 3'd0;
                        r_stage <= 3'd0;
                        r_round <= 8'd0;
                    end
                end
                S_RUN: begin
                    if (w_sample) begin
                        r_stage <= 3'd0;
                        r_vec   <= r_vec + 3'd1;
                        if (r_vec == 3'd7) begin
                            r_round <= r_round + 8'd1;
                        end
                        if (w_last) begin
                            r_state <= S_FINISH;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_stage <= r_stage + 3'd1;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Result accumulation. Results are cleared on an accepted start and
    // updated at each sample. pass is resolved on the final sample, so an
    // error on the final vector is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass    <= 1'b0;
            r_err     <= 8'd0;
            r_ffv     <= 3'd0;
            r_ffvalid <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_pass    <= 1'b0;
            r_err     <= 8'd0;
            r_ffv     <= 3'd0;
            r_ffvalid <= 1'b0;
        end else if (w_sample) begin
            r_err <= w_err_next;
            if (w_mis && !r_ffvalid) begin
                r_ffv     <= r_vec;
                r_ffvalid <= 1'b1;
            end
            if (w_last) begin
                r_pass <= (w_err_next == 8'd0);
            end
        end
    end

endmodule

// File: tb/tb_full_adder_bist.sv
module tb_full_adder_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start2, start40;

    logic a0, b0, c0, s0, co0, busy0, done0, pass0, ffvalid0;
    logic [7:0] err0;
    logic [2:0] ffv0;
    logic a2, b2, c2, s2, co2, busy2, done2, pass2, ffvalid2;
    logic [7:0] err2;
    logic [2:0] ffv2;
    logic a40, b40, c40, s40, co40, busy40, done40, pass40, ffvalid40;
    logic [7:0] err40;
    logic [2:0] ffv40;

    // Fault behaviour of the adder on u0:
    // 0 ideal, 1 sum stuck-at-0, 2 cout inverted,
    // 3 both outputs wrong on vector 7 only, 4 two-stage pipelined adder
    int mode0 = 0;

    logic [2:0] pa1_0 = 3'd0, pa2_0 = 3'd0, pa1_2 = 3'd0, pa2_2 = 3'd0;

    typedef struct packed {
        logic       pass;
        logic [7:0] err;
        logic [2:0] ffv;
        logic       ffvalid;
    } res_t;

    res_t q0[$];
    res_t q2[$];
    res_t q40[$];
    int checks = 0;
    int errors = 0;
    int bc;

    full_adder_bist #(.LAT(0), .ROUNDS(1)) u0 (
        .clk(clk), .rst(rst), .start(start0),
        .dut_a(a0), .dut_b(b0), .dut_cin(c0), .dut_sum(s0), .dut_cout(co0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffvalid0));

    full_adder_bist #(.LAT(2), .ROUNDS(1)) u2 (
        .clk(clk), .rst(rst), .start(start2),
        .dut_a(a2), .dut_b(b2), .dut_cin(c2), .dut_sum(s2), .dut_cout(co2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffv2), .first_fail_valid(ffvalid2));

    full_adder_bist #(.LAT(0), .ROUNDS(40)) u40 (
        .clk(clk), .rst(rst), .start(start40),
        .dut_a(a40), .dut_b(b40), .dut_cin(c40), .dut_sum(s40), .dut_cout(co40),
        .busy(busy40), .done(done40), .pass(pass40), .err_count(err40),
        .first_fail_vec(ffv40), .first_fail_valid(ffvalid40));

    function automatic logic fa_sum(input logic [2:0] v);
        return v[2] ^ v[1] ^ v[0];
    endfunction

    function automatic logic fa_cout(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    // Two-register input pipelines feeding the pipelined adder models
    always @(posedge clk) begin
        pa1_0 <= {a0, b0, c0};
        pa2_0 <= pa1_0;
        pa1_2 <= {a2, b2, c2};
        pa2_2 <= pa1_2;
    end

    always_comb begin
        s0  = fa_sum({a0, b0, c0});
        co0 = fa_cout({a0, b0, c0});
        case (mode0)
            1: s0 = 1'b0;
            2: co0 = ~fa_cout({a0, b0, c0});
            3: if ({a0, b0, c0} == 3'd7) begin
                s0  = ~fa_sum({a0, b0, c0});
                co0 = ~fa_cout({a0, b0, c0});
            end
            4: begin
                s0  = fa_sum(pa2_0);
                co0 = fa_cout(pa2_0);
            end
            default: ;
        endcase
    end

    assign s2   = fa_sum(pa2_2);
    assign co2  = fa_cout(pa2_2);
    assign s40  = fa_sum({a40, b40, c40});
    assign co40 = ~fa_cout({a40, b40, c40});

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t mk(input logic p, input logic [7:0] e, input logic [2:0] v, input logic fv);
        res_t r;
        r.pass = p; r.err = e; r.ffv = v; r.ffvalid = fv;
        return r;
    endfunction

    task automatic chk_res(input string name, input res_t e, input logic p, input logic [7:0] er,
                           input logic [2:0] v, input logic fv);
        chk({name, "_pass"}, int'(p), int'(e.pass));
        chk({name, "_err_count"}, int'(er), int'(e.err));
        chk({name, "_first_fail_vec"}, int'(v), int'(e.ffv));
        chk({name, "_first_fail_valid"}, int'(fv), int'(e.ffvalid));
    endtask

    // Monitors: every done pulse is matched against the oldest queued expectation
    always @(negedge clk) begin
        res_t e;
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL u0_unexpected_done: got done=1 expected no pending run");
            end else begin
                e = q0.pop_front();
                chk_res("u0", e, pass0, err0, ffv0, ffvalid0);
            end
        end
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL u2_unexpected_done: got done=1 expected no pending run");
            end else begin
                e = q2.pop_front();
                chk_res("u2", e, pass2, err2, ffv2, ffvalid2);
            end
        end
        if (done40 === 1'b1) begin
            if (q40.size() == 0) begin
                checks++; errors++;
                $display("FAIL u40_unexpected_done: got done=1 expected no pending run");
            end else begin
                e = q40.pop_front();
                chk_res("u40", e, pass40, err40, ffv40, ffvalid40);
            end
        end
    end

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: start0 = 1'b1;
            2: start2 = 1'b1;
            default: start40 = 1'b1;
        endcase
        @(negedge clk);
        start0 = 1'b0; start2 = 1'b0; start40 = 1'b0;
    endtask

    // Waits (bounded) for done on one instance, counting busy cycles on the way
    task automatic wait_done(input int which, input int budget, output int busy_cycles);
        int  n = 0;
        bit  seen = 0;
        logic d, b;
        busy_cycles = 0;
        while (!seen && n < budget) begin
            case (which)
                0: begin d = done0; b = busy0; end
                2: begin d = done2; b = busy2; end
                default: begin d = done40; b = busy40; end
            endcase
            if (d === 1'b1) seen = 1;
            else begin
                if (b === 1'b1) busy_cycles++;
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout_u%0d: got no done in %0d cycles expected done", which, budget);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; start40 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state_u0", int'({a0, b0, c0, busy0, done0, pass0, err0, ffv0, ffvalid0}), 0);
        chk("reset_state_u2", int'({a2, b2, c2, busy2, done2, pass2, err2, ffv2, ffvalid2}), 0);
        chk("reset_state_u40", int'({a40, b40, c40, busy40, done40, pass40, err40, ffv40, ffvalid40}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ideal adder: vectors 0..7 in order, one per cycle, busy for 8 cycles
        mode0 = 0;
        q0.push_back(mk(1'b1, 8'd0, 3'd0, 1'b0));
        pulse(0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ideal_busy_c%0d", i), int'(busy0), 1);
            chk($sformatf("ideal_vec_c%0d", i), int'({a0, b0, c0}), i);
            @(negedge clk);
        end
        chk("ideal_finish_busy", int'(busy0), 0);
        chk("ideal_finish_done", int'(done0), 1);
        @(negedge clk);
        chk("ideal_done_one_cycle", int'(done0), 0);
        repeat (4) @(negedge clk);
        chk("ideal_pass_held", int'(pass0), 1);

        // Sum stuck-at-0: vectors 1,2,4,7 fail
        mode0 = 1;
        q0.push_back(mk(1'b0, 8'd4, 3'd1, 1'b1));
        pulse(0);
        wait_done(0, 100, bc);
        chk("stuck_sum_busy_cycles", bc, 8);
        repeat (5) @(negedge clk);
        chk("stuck_sum_err_held", int'(err0), 4);

        // Inverted cout: every vector fails, and the count restarts from 0
        mode0 = 2;
        q0.push_back(mk(1'b0, 8'd8, 3'd0, 1'b1));
        pulse(0);
        wait_done(0, 100, bc);
        repeat (2) @(negedge clk);

        // Both outputs wrong on vector 7 only: one error, not two
        mode0 = 3;
        q0.push_back(mk(1'b0, 8'd1, 3'd7, 1'b1));
        pulse(0);
        wait_done(0, 100, bc);
        repeat (2) @(negedge clk);

        // Two-stage pipelined adder sampled at LAT=2: 24-cycle run, passes
        q2.push_back(mk(1'b1, 8'd0, 3'd0, 1'b0));
        pulse(2);
        wait_done(2, 200, bc);
        chk("lat2_busy_cycles", bc, 24);
        repeat (2) @(negedge clk);

        // Same pipelined adder sampled at LAT=0: responses lag by two vectors
        // and mismatch on vectors 1,2,3,6,7
        mode0 = 4;
        q0.push_back(mk(1'b0, 8'd5, 3'd1, 1'b1));
        pulse(0);
        wait_done(0, 100, bc);
        repeat (2) @(negedge clk);

        // 40 rounds with inverted cout: 320 errors saturate at 255
        q40.push_back(mk(1'b0, 8'd255, 3'd0, 1'b1));
        pulse(40);
        wait_done(40, 2000, bc);
        chk("rounds40_busy_cycles", bc, 320);
        repeat (2) @(negedge clk);

        // start mid-run is ignored: the run still ends on schedule with one done
        mode0 = 1;
        q0.push_back(mk(1'b0, 8'd4, 3'd1, 1'b1));
        pulse(0);
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 100, bc);
        chk("midrun_start_remaining_busy", bc, 5);
        repeat (15) @(negedge clk);
        chk("midrun_start_idle_busy", int'(busy0), 0);

        // rst during run cycle 3: all outputs 0 next cycle and no done
        mode0 = 1;
        pulse(0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs_zero", int'({a0, b0, c0, busy0, done0, pass0, err0, ffv0, ffvalid0}), 0);
        repeat (12) @(negedge clk);
        chk("abort_stays_idle", int'({busy0, done0}), 0);

        // A clean full sweep after the aborted run
        mode0 = 0;
        q0.push_back(mk(1'b1, 8'd0, 3'd0, 1'b0));
        pulse(0);
        wait_done(0, 100, bc);
        chk("after_abort_busy_cycles", bc, 8);
        repeat (3) @(negedge clk);

        chk("q0_drained", q0.size(), 0);
        chk("q2_drained", q2.size(), 0);
        chk("q40_drained", q40.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
